// File: rtl/seg_scan_scheduler_if.sv
// ---------------------------------------------------------------------------
// seg_scan_scheduler_if
//   Write/commit port of the 7-segment scan scheduler.
//
//   Handshake: a write transfers on a rising clock edge where wr_valid and
//   wr_ready are both 1. The master holds wr_index/wr_value stable while
//   wr_valid is high. wr_ready does not depend on wr_valid.
//   commit_req is a one-cycle pulse from the master. commit_done is a
//   one-cycle pulse from the slave, raised when the shadow values go live.
//
//   Signals:
//     wr_valid    master -> slave  write request
//     wr_ready    slave  -> master write can be accepted this cycle
//     wr_index    master -> slave  target digit, 0 = rightmost
//     wr_value    master -> slave  hex value 0x0..0xF
//     commit_req  master -> slave  publish request pulse
//     commit_done slave  -> master publish happened pulse
// ---------------------------------------------------------------------------
interface seg_scan_scheduler_if #(
    parameter int NUM_DIGITS = 4
) ();
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_index;
    logic [3:0]       wr_value;
    logic             commit_req;
    logic             commit_done;

    modport master (
        output wr_valid,
        output wr_index,
        output wr_value,
        output commit_req,
        input  wr_ready,
        input  commit_done
    );

    modport slave (
        input  wr_valid,
        input  wr_index,
        input  wr_value,
        input  commit_req,
        output wr_ready,
        output commit_done
    );
endinterface

// File: rtl/seg_scan_scheduler.sv
// ---------------------------------------------------------------------------
// seg_scan_scheduler
//   Time-multiplexes one shared 7-segment bus across NUM_DIGITS digit
//   enables. Each digit slot lasts TICK_DIV cycles. The first BLANK_CYCLES
//   cycles of a slot are dark, so the previous digit's segments cannot ghost
//   onto the next digit. Digit values are written into a shadow array. A
//   commit request copies the shadow array into the displayed (active) array
//   at the next frame boundary. A frame boundary is the wrap from digit
//   NUM_DIGITS-1 to digit 0. If the display is stopped, the copy happens at
//   once. Because of this, a frame never shows a mix of old and new values.
//
//   Optional build macro: SEG_LEADING_ZERO_BLANK_EN
//     When defined, leading zero digits above digit 0 stay dark during
//     their slot. Slot timing does not change.
//
//   Ports:
//     clock      system clock, rising edge
//     reset      synchronous, active-high
//     run        1 = scan; 0 = dark, scan position held
//     wr_if      write/commit port (slave side of seg_scan_scheduler_if)
//     led        segments {g,f,e,d,c,b,a}, active-high, registered
//     digit_en   one-hot-or-zero digit select, registered
//     dbg_state  current scan FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module seg_scan_scheduler #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 27_000,
    parameter int BLANK_CYCLES = 270
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    seg_scan_scheduler_if.slave   wr_if,
    output logic [6:0]            led,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [1:0]            dbg_state
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [CNT_W-1:0] slot_cnt, slot_cnt_d;
    logic             pending;
    logic             publish;
    logic             wr_accept;
    logic [3:0]       shadow [NUM_DIGITS];
    logic [3:0]       active [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lit_mask;
    logic [6:0]            led_d;
    logic [NUM_DIGITS-1:0] digit_en_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // The port accepts writes only while no commit is pending. This
    // guarantees that the shadow array cannot change between the commit
    // request and the copy.
    assign wr_if.wr_ready = ~pending;
    assign wr_accept      = wr_if.wr_valid & ~pending;
    assign dbg_state      = state;

    // Digits that may light during their slot.
`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic nz;
        nz       = 1'b0;
        lit_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz          = nz | (active[i] != 4'h0);
            lit_mask[i] = nz | (i == 0);
        end
    end
`else
    always_comb begin
        lit_mask = '1;
    end
`endif

    // Scan FSM: next state, scan position and publish decision.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        slot_cnt_d = slot_cnt;
        publish    = 1'b0;
        case (state)
            S_OFF: begin
                slot_cnt_d = '0;
                // When the display is stopped, there is no frame to tear, so
                // the copy happens at once.
                publish    = pending;
                if (run) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (!run) begin
                    state_d    = S_OFF;
                    slot_cnt_d = '0;
                end else begin
                    slot_cnt_d = slot_cnt + 1'b1;
                    if (slot_cnt == BLANK_LAST) begin
                        state_d = S_SHOW;
                    end
                end
            end
            S_SHOW: begin
                if (!run) begin
                    state_d    = S_OFF;
                    slot_cnt_d = '0;
                end else if (slot_cnt == TICK_LAST) begin
                    slot_cnt_d = '0;
                    state_d    = S_BLANK;
                    if (idx == IDX_LAST) begin
                        idx_d   = '0;
                        publish = pending;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end else begin
                    slot_cnt_d = slot_cnt + 1'b1;
                end
            end
            default: begin
                state_d    = S_OFF;
                slot_cnt_d = '0;
            end
        endcase
    end

    // The outputs follow the state entered at this edge. A copy only happens
    // on a transition into S_OFF or S_BLANK, so the active array is already
    // stable whenever S_SHOW is entered or held.
    always_comb begin
        led_d      = '0;
        digit_en_d = '0;
        if (state_d == S_SHOW && lit_mask[idx_d]) begin
            led_d             = seg_decode(active[idx_d]);
            digit_en_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= S_OFF;
            idx               <= '0;
            slot_cnt          <= '0;
            pending           <= 1'b0;
            led               <= '0;
            digit_en          <= '0;
            wr_if.commit_done <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= 4'h0;
                active[i] <= 4'h0;
            end
        end else begin
            state             <= state_d;
            idx               <= idx_d;
            slot_cnt          <= slot_cnt_d;
            led               <= led_d;
            digit_en          <= digit_en_d;
            wr_if.commit_done <= publish;

            // A request that arrives while a commit is pending is ignored.
            // This includes a request on the publishing edge itself.
            if (publish) begin
                pending <= 1'b0;
            end else if (wr_if.commit_req && !pending) begin
                pending <= 1'b1;
            end

            // A write is accepted only while pending=0, and a copy only
            // happens while pending=1, so the two never overlap.
            if (wr_accept && (int'(wr_if.wr_index) < NUM_DIGITS)) begin
                shadow[wr_if.wr_index] <= wr_if.wr_value;
            end

            if (publish) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end
endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
- Time-multiplexes one shared 7-segment bus (`led`) across NUM_DIGITS common-select digit enables, so several hex digits appear on one display.
- Sits between the Bluetooth/UART byte decoder, which writes digit values through a valid/ready port, and the display pins.
- Uses a prescaler-driven scan FSM with a per-slot anti-ghost blanking window.
- Writes are double-buffered; they go live only on a frame boundary after a commit request, so no tearing.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; must be 2..8.
- TICK_DIV, 27_000, clock cycles per digit slot; must be at least 2. The default gives 1 kHz per slot at 27 MHz.
- BLANK_CYCLES, 270, cycles at the start of each slot with all digits off; must be at least 1 and less than TICK_DIV.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = scan display; 0 = display dark, scan position held.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready at a clock edge.
- wr_index  in  $clog2(NUM_DIGITS)  target digit; 0 = rightmost.
- wr_value  in  4  hex value 0x0-0xF.
- commit_req  in  1  one-cycle pulse: publish shadow values at next frame boundary.
- commit_done  out  1  one-cycle pulse when the shadow-to-active copy happens.
- led  out  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- digit_en  out  NUM_DIGITS  one-hot-or-zero digit select, active-high, registered.

Behaviour:
- Clock, reset and sampling
  - One clock (`clock`); reset (`reset`) is synchronous and active-high.
  - Reset values: state=S_OFF, digit idx=0, slot_cnt=0, shadow[] and active[] all 0, pending=0, led=0, digit_en=0, commit_done=0.
- Write port and commit
  - wr_ready = ~pending (combinational). It is 1 after reset.
  - An accepted write sets shadow[wr_index]=wr_value at that edge. wr_index >= NUM_DIGITS is accepted and discarded.
  - commit_req sets pending=1 at the next edge. commit_req while pending=1 is ignored.
  - A write accepted in the same cycle as commit_req is included in that commit.
- FSM states
  - S_OFF: led=0, digit_en=0, slot_cnt held at 0. If pending=1, copy shadow to active at the next edge, clear pending and pulse commit_done. If run=1, go to S_BLANK with the current idx.
  - S_BLANK: led=0, digit_en=0; slot_cnt increments. Go to S_SHOW when slot_cnt reaches BLANK_CYCLES-1.
  - S_SHOW: digit_en[idx]=1, led=decode(active[idx]); slot_cnt increments. When slot_cnt reaches TICK_DIV-1:
    - slot_cnt=0; idx=idx+1, wrapping NUM_DIGITS-1 to 0; go to S_BLANK.
    - Frame boundary is the wrap from NUM_DIGITS-1 to 0. At that edge, if pending=1, copy all active[]=shadow[], clear pending, and drive commit_done=1 for exactly one cycle.
  - run=0 in S_BLANK or S_SHOW: go to S_OFF next edge with slot_cnt=0 and idx held. Resuming restarts that digit's slot from blanking.
- Timing
  - Outputs are registered and reflect the state entered at the same edge.
  - A full slot is exactly TICK_DIV cycles: BLANK_CYCLES dark, then TICK_DIV-BLANK_CYCLES lit.
  - A full frame is NUM_DIGITS*TICK_DIV cycles.
  - A commit_req pulse in the same cycle as the boundary edge misses that boundary and publishes at the next one.
- Decode (hex to {g..a})
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Reset mid-operation discards shadow contents, any pending commit and the current scan position.

Optional Feature:
- SEG_LEADING_ZERO_BLANK_EN
  - Defined: in S_SHOW, digit idx>0 is blanked (led=0, digit_en=0, slot timing unchanged) if active[idx] and all active[] above it are 0. Digit 0 is never blanked.
  - Undefined: every digit is always lit in S_SHOW.

Test Plan:
All scenarios use NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
1. Reset, then run=1 held:
   - One cycle S_OFF, then digit_en=0 for 2 cycles, then digit_en=0001 with led=3F for 6 cycles.
   - Then 0010, 0100, 1000; frame period 32 cycles.
2. Write idx2=5, commit_req mid-frame:
   - wr_ready=0 until the next 3-to-0 wrap; digit2 still shows 3F before it.
   - At the boundary commit_done=1 for one cycle; after it digit2 shows 6D.
3. Hold wr_valid (idx1=A) while pending=1:
   - Not accepted until wr_ready returns to 1; then shadow updated, but active unchanged until a later commit.
4. run=0 during digit1 S_SHOW:
   - Next cycle led=0, digit_en=0.
   - run=1 again: 2 dark cycles, then digit_en=0010 for 6 cycles.
5. Reset asserted mid-frame with pending=1:
   - Next cycle all outputs 0, wr_ready=1; no commit_done thereafter.
6. Active values {d3..d0}={0,0,1,0}:
   - With macro: digit3 and digit2 slots dark, digit1 shows 06, digit0 shows 3F.
   - Without macro: digit3 and digit2 show 3F.
